idu_controller: RTL and testbench
=================================

IDU_CONTROLLER -- requirements
Module: idu_controller

Interface
REQ-001 Parameter: NUM_REQ, 3, number of requesters; index 0 = PC, 1 = SP, 2 = HL.
REQ-002 i_Clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 i_Reset  input  1  asynchronous, active-high reset.
REQ-004 i_Req  input  NUM_REQ  per-requester request, level.
REQ-005 i_Decrement  input  NUM_REQ  per-requester direction; 1 = decrement, 0 = increment.
REQ-006 i_Operand  input  16*NUM_REQ  packed 16-bit operands; requester k occupies bits [16k+15:16k].
REQ-007 o_Ack  output  NUM_REQ  one-hot, one-cycle completion pulse to the served requester.
REQ-008 o_Result  output  16  incremented/decremented value; valid only while o_Ack is nonzero.
REQ-009 o_Wrap  output  1  asserted with o_Ack when 0xFFFF->0x0000 or 0x0000->0xFFFF occurred.
REQ-010 o_Busy  output  1  high in every state except IDLE.
REQ-011 o_Inc_Operand  output  8  byte presented to the external 8-bit incrementer.
REQ-012 o_Inc_Decrement  output  1  direction presented to the 8-bit incrementer.
REQ-013 i_Inc_Result  input  8  combinational result returned by the incrementer in the same cycle.
REQ-014 i_Inc_Carry  input  1  incrementer carry (0xFF->0x00) or borrow (0x00->0xFF).

Function
REQ-015 States: IDLE, LOW, HIGH, DONE, encoded in a registered FSM.
REQ-016 IDLE: if any i_Req bit is high, grant the lowest index (fixed priority), capture its operand, direction and index, and go to LOW; otherwise stay in IDLE.
REQ-017 LOW: drive captured operand[7:0] and direction to the incrementer, register i_Inc_Result as result low byte and i_Inc_Carry as carry, and go to HIGH.
REQ-018 HIGH: if carry is 1, drive operand[15:8] to the incrementer and register its result and carry as the high byte and wrap; if carry is 0, pass operand[15:8] through with wrap = 0; then go to DONE.
REQ-019 DONE: assert o_Ack[granted index], o_Result and o_Wrap for exactly one cycle, then go to IDLE.
REQ-020 Latency: the request is sampled in cycle N and o_Ack is asserted in cycle N+3.
REQ-021 Operand and direction are captured at grant; changes to i_Operand, i_Decrement or i_Req during LOW/HIGH/DONE are ignored, and the granted operation always completes and acks.
REQ-022 A requester deasserts i_Req in the cycle after its ack; a request still high in IDLE is treated as a new request.
REQ-023 Simultaneous requests: exactly one is granted; losers wait with i_Req held and are served on later IDLE visits.
REQ-024 o_Inc_Operand and o_Inc_Decrement are 0 in IDLE and DONE.
REQ-025 Arithmetic is modulo 2^16; a 16-bit wrap is signalled only via o_Wrap.

Reset
REQ-026 While i_Reset is high: state = IDLE; o_Ack = 0, o_Result = 0x0000, o_Wrap = 0, o_Busy = 0, o_Inc_Operand = 0x00, o_Inc_Decrement = 0; all captured registers = 0.
REQ-027 Reset mid-operation aborts without any ack; after reset release, a still-asserted request is re-arbitrated from IDLE.

Configuration
REQ-028 Macro IDU_SKIP_HIGH_EN: when defined, LOW goes directly to DONE when the low-byte carry is 0, giving latency N+2; carry = 1 still passes through HIGH (N+3).
REQ-029 When IDU_SKIP_HIGH_EN is undefined, every operation visits HIGH and latency is always N+3.

Structure
REQ-030 Package idu_pkg holds the state enum, the NUM_REQ default, and the constants REQ_PC = 0, REQ_SP = 1, REQ_HL = 2.
REQ-031 Sub-module idu_priority_arbiter: a combinational lowest-index-wins one-hot grant plus encoded index, instantiated once.

Verification
REQ-032 PC req, inc, operand 0x12FF -> o_Ack = 001 at N+3, o_Result = 0x1300, o_Wrap = 0.
REQ-033 HL req, dec, operand 0x0000 -> o_Ack = 100, o_Result = 0xFFFF, o_Wrap = 1; SP inc 0xFFFF -> 0x0000, o_Wrap = 1.
REQ-034 PC and SP both request in the same cycle -> PC acked first (001), SP acked next (010) after an IDLE cycle, with correct results for both.
REQ-035 SP inc 0xC000, with i_Operand changed to 0x5555 during LOW -> o_Result = 0xC001.
REQ-036 i_Reset pulsed during HIGH -> no ack, all outputs 0; held request re-served with correct result after release.
REQ-037 IDU_SKIP_HIGH_EN defined: inc 0x0010 -> ack at N+2 with 0x0011; inc 0x00FF -> ack at N+3 with 0x0100.

Source files
------------

// File: rtl/idu_pkg.sv
// idu_pkg: shared state encoding, requester indices and default requester count
package idu_pkg;
  localparam int NUM_REQ_DEF = 3;
  localparam int REQ_PC = 0;
  localparam int REQ_SP = 1;
  localparam int REQ_HL = 2;
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
endpackage

// File: rtl/idu_if.sv
// idu_if: requester bus plus external 8-bit incrementer link of the idu_controller
interface idu_if import idu_pkg::*; #(parameter int NUM_REQ = NUM_REQ_DEF);
  logic [NUM_REQ-1:0] i_Req;
  logic [NUM_REQ-1:0] i_Decrement;
  logic [16*NUM_REQ-1:0] i_Operand;
  logic [NUM_REQ-1:0] o_Ack;
  logic [15:0] o_Result;
  logic o_Wrap;
  logic o_Busy;
  logic [7:0] o_Inc_Operand;
  logic o_Inc_Decrement;
  logic [7:0] i_Inc_Result;
  logic i_Inc_Carry;
  modport slave (
    input i_Req, i_Decrement, i_Operand, i_Inc_Result, i_Inc_Carry,
    output o_Ack, o_Result, o_Wrap, o_Busy, o_Inc_Operand, o_Inc_Decrement
  );
  modport master (
    output i_Req, i_Decrement, i_Operand, i_Inc_Result, i_Inc_Carry,
    input o_Ack, o_Result, o_Wrap, o_Busy, o_Inc_Operand, o_Inc_Decrement
  );
endinterface

// File: rtl/idu_priority_arbiter.sv
// idu_priority_arbiter: combinational lowest-index-wins one-hot grant and encoded index
module idu_priority_arbiter #(
  parameter int NUM_REQ = 3,
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx
);
  assign grant = req & (~req + NUM_REQ'(1));
  always_comb begin
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) if (req[i]) idx = IW'(i);
  end
endmodule

// File: rtl/idu_controller.sv
// idu_controller: 16-bit inc/dec sequencer built on an external 8-bit incrementer.
// IDU_SKIP_HIGH_EN: skip the HIGH state when the low byte produced no carry.
module idu_controller import idu_pkg::*; #(
  parameter int NUM_REQ = NUM_REQ_DEF,
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input logic i_Clk,
  input logic i_Reset,
  idu_if.slave bus
);
  state_t state;
  logic [15:0] op;
  logic dec, carry;
  logic [7:0] res_lo;
  logic [IW-1:0] idx, gidx;
  logic [NUM_REQ-1:0] grant;
  idu_priority_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (.req(bus.i_Req), .grant(grant), .idx(gidx));
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state <= IDLE;
      op <= '0;
      dec <= 1'b0;
      carry <= 1'b0;
      res_lo <= '0;
      idx <= '0;
      bus.o_Ack <= '0;
      bus.o_Result <= '0;
      bus.o_Wrap <= 1'b0;
      bus.o_Busy <= 1'b0;
      bus.o_Inc_Operand <= '0;
      bus.o_Inc_Decrement <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|grant) begin
          state <= LOW;
          op <= bus.i_Operand[16*gidx +: 16];
          dec <= bus.i_Decrement[gidx];
          idx <= gidx;
          bus.o_Busy <= 1'b1;
          bus.o_Inc_Operand <= bus.i_Operand[16*gidx +: 8];
          bus.o_Inc_Decrement <= bus.i_Decrement[gidx];
        end
        LOW: begin
          res_lo <= bus.i_Inc_Result;
          carry <= bus.i_Inc_Carry;
`ifdef IDU_SKIP_HIGH_EN
          if (!bus.i_Inc_Carry) begin
            state <= DONE;
            bus.o_Ack <= NUM_REQ'(1) << idx;
            bus.o_Result <= {op[15:8], bus.i_Inc_Result};
            bus.o_Wrap <= 1'b0;
            bus.o_Inc_Operand <= '0;
            bus.o_Inc_Decrement <= 1'b0;
          end else begin
            state <= HIGH;
            bus.o_Inc_Operand <= op[15:8];
          end
`else
          state <= HIGH;
          bus.o_Inc_Operand <= op[15:8];
`endif
        end
        HIGH: begin
          // high byte only goes through the incrementer when the low byte carried
          state <= DONE;
          bus.o_Ack <= NUM_REQ'(1) << idx;
          bus.o_Result <= {carry ? bus.i_Inc_Result : op[15:8], res_lo};
          bus.o_Wrap <= carry & bus.i_Inc_Carry;
          bus.o_Inc_Operand <= '0;
          bus.o_Inc_Decrement <= 1'b0;
        end
        default: begin
          state <= IDLE;
          bus.o_Ack <= '0;
          bus.o_Result <= '0;
          bus.o_Wrap <= 1'b0;
          bus.o_Busy <= 1'b0;
        end
      endcase
    end
  end
  logic unused;
  assign unused = dec;
endmodule

// File: tb/tb_idu_controller.sv
// tb_idu_controller: directed self-checking bench with a behavioural 8-bit incrementer
module tb_idu_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  int n;
  idu_if #(.NUM_REQ(3)) bus();
  idu_controller #(.NUM_REQ(3)) dut (.i_Clk(clk), .i_Reset(rst), .bus(bus));
  always #5 clk = ~clk;
  always_comb begin
    bus.i_Inc_Result = bus.o_Inc_Decrement ? bus.o_Inc_Operand - 8'd1 : bus.o_Inc_Operand + 8'd1;
    bus.i_Inc_Carry = bus.o_Inc_Decrement ? (bus.o_Inc_Operand == 8'h00) : (bus.o_Inc_Operand == 8'hFF);
  end
`ifdef IDU_SKIP_HIGH_EN
  localparam int LAT_NC = 2;
`else
  localparam int LAT_NC = 3;
`endif
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_ack(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (bus.o_Ack == 3'b000 && cnt < 8);
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.i_Req = '0;
    bus.i_Decrement = '0;
    bus.i_Operand = '0;
    tick();
    tick();
    n_checks++; if (bus.o_Ack !== 3'b000) begin n_fail++; $display("FAIL reset_ack got %b exp 000", bus.o_Ack); end
    n_checks++; if (bus.o_Result !== 16'h0000) begin n_fail++; $display("FAIL reset_result got %h exp 0000", bus.o_Result); end
    n_checks++; if (bus.o_Wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap got %b exp 0", bus.o_Wrap); end
    n_checks++; if (bus.o_Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus.o_Busy); end
    n_checks++; if (bus.o_Inc_Operand !== 8'h00) begin n_fail++; $display("FAIL reset_inc_op got %h exp 00", bus.o_Inc_Operand); end
    n_checks++; if (bus.o_Inc_Decrement !== 1'b0) begin n_fail++; $display("FAIL reset_inc_dec got %b exp 0", bus.o_Inc_Decrement); end
    rst = 1'b0;
    tick();
  endtask
  task automatic test_inc_pc();
    bus.i_Operand = {16'h0, 16'h0, 16'h12FF};
    bus.i_Decrement = 3'b000;
    bus.i_Req = 3'b001;
    tick();
    n_checks++; if (bus.o_Busy !== 1'b1) begin n_fail++; $display("FAIL pc_low_busy got %b exp 1", bus.o_Busy); end
    n_checks++; if (bus.o_Inc_Operand !== 8'hFF) begin n_fail++; $display("FAIL pc_low_inc_op got %h exp FF", bus.o_Inc_Operand); end
    n_checks++; if (bus.o_Ack !== 3'b000) begin n_fail++; $display("FAIL pc_low_ack got %b exp 000", bus.o_Ack); end
    tick();
    n_checks++; if (bus.o_Inc_Operand !== 8'h12) begin n_fail++; $display("FAIL pc_high_inc_op got %h exp 12", bus.o_Inc_Operand); end
    n_checks++; if (bus.o_Ack !== 3'b000) begin n_fail++; $display("FAIL pc_high_ack got %b exp 000", bus.o_Ack); end
    tick();
    n_checks++; if (bus.o_Ack !== 3'b001) begin n_fail++; $display("FAIL pc_done_ack got %b exp 001", bus.o_Ack); end
    n_checks++; if (bus.o_Result !== 16'h1300) begin n_fail++; $display("FAIL pc_done_result got %h exp 1300", bus.o_Result); end
    n_checks++; if (bus.o_Wrap !== 1'b0) begin n_fail++; $display("FAIL pc_done_wrap got %b exp 0", bus.o_Wrap); end
    n_checks++; if (bus.o_Inc_Operand !== 8'h00) begin n_fail++; $display("FAIL pc_done_inc_op got %h exp 00", bus.o_Inc_Operand); end
    bus.i_Req = 3'b000;
    tick();
    n_checks++; if (bus.o_Ack !== 3'b000) begin n_fail++; $display("FAIL pc_idle_ack got %b exp 000", bus.o_Ack); end
    n_checks++; if (bus.o_Busy !== 1'b0) begin n_fail++; $display("FAIL pc_idle_busy got %b exp 0", bus.o_Busy); end
  endtask
  task automatic test_wrap();
    bus.i_Operand = {16'h0000, 16'hFFFF, 16'h0};
    bus.i_Decrement = 3'b100;
    bus.i_Req = 3'b100;
    wait_ack(n);
    bus.i_Req = 3'b000;
    n_checks++; if (n !== 3) begin n_fail++; $display("FAIL hl_dec_latency got %0d exp 3", n); end
    n_checks++; if (bus.o_Ack !== 3'b100) begin n_fail++; $display("FAIL hl_dec_ack got %b exp 100", bus.o_Ack); end
    n_checks++; if (bus.o_Result !== 16'hFFFF) begin n_fail++; $display("FAIL hl_dec_result got %h exp FFFF", bus.o_Result); end
    n_checks++; if (bus.o_Wrap !== 1'b1) begin n_fail++; $display("FAIL hl_dec_wrap got %b exp 1", bus.o_Wrap); end
    tick();
    bus.i_Decrement = 3'b000;
    bus.i_Req = 3'b010;
    wait_ack(n);
    bus.i_Req = 3'b000;
    n_checks++; if (n !== 3) begin n_fail++; $display("FAIL sp_inc_latency got %0d exp 3", n); end
    n_checks++; if (bus.o_Ack !== 3'b010) begin n_fail++; $display("FAIL sp_inc_ack got %b exp 010", bus.o_Ack); end
    n_checks++; if (bus.o_Result !== 16'h0000) begin n_fail++; $display("FAIL sp_inc_result got %h exp 0000", bus.o_Result); end
    n_checks++; if (bus.o_Wrap !== 1'b1) begin n_fail++; $display("FAIL sp_inc_wrap got %b exp 1", bus.o_Wrap); end
    tick();
  endtask
  task automatic test_back_to_back();
    bus.i_Operand = {16'h0, 16'h1000, 16'h0041};
    bus.i_Decrement = 3'b010;
    bus.i_Req = 3'b011;
    wait_ack(n);
    bus.i_Req = 3'b010;
    n_checks++; if (n !== LAT_NC) begin n_fail++; $display("FAIL b2b_pc_latency got %0d exp %0d", n, LAT_NC); end
    n_checks++; if (bus.o_Ack !== 3'b001) begin n_fail++; $display("FAIL b2b_pc_ack got %b exp 001", bus.o_Ack); end
    n_checks++; if (bus.o_Result !== 16'h0042) begin n_fail++; $display("FAIL b2b_pc_result got %h exp 0042", bus.o_Result); end
    tick();
    n_checks++; if (bus.o_Ack !== 3'b000) begin n_fail++; $display("FAIL b2b_idle_ack got %b exp 000", bus.o_Ack); end
    n_checks++; if (bus.o_Busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_busy got %b exp 0", bus.o_Busy); end
    wait_ack(n);
    bus.i_Req = 3'b000;
    n_checks++; if (n !== 3) begin n_fail++; $display("FAIL b2b_sp_latency got %0d exp 3", n); end
    n_checks++; if (bus.o_Ack !== 3'b010) begin n_fail++; $display("FAIL b2b_sp_ack got %b exp 010", bus.o_Ack); end
    n_checks++; if (bus.o_Result !== 16'h0FFF) begin n_fail++; $display("FAIL b2b_sp_result got %h exp 0FFF", bus.o_Result); end
    n_checks++; if (bus.o_Wrap !== 1'b0) begin n_fail++; $display("FAIL b2b_sp_wrap got %b exp 0", bus.o_Wrap); end
    tick();
  endtask
  task automatic test_capture();
    bus.i_Operand = {16'h0, 16'hC000, 16'h0};
    bus.i_Decrement = 3'b000;
    bus.i_Req = 3'b010;
    tick();
    bus.i_Operand = {3{16'h5555}};
    bus.i_Decrement = 3'b111;
    wait_ack(n);
    bus.i_Req = 3'b000;
    n_checks++; if (n + 1 !== LAT_NC) begin n_fail++; $display("FAIL cap_latency got %0d exp %0d", n + 1, LAT_NC); end
    n_checks++; if (bus.o_Ack !== 3'b010) begin n_fail++; $display("FAIL cap_ack got %b exp 010", bus.o_Ack); end
    n_checks++; if (bus.o_Result !== 16'hC001) begin n_fail++; $display("FAIL cap_result got %h exp C001", bus.o_Result); end
    tick();
  endtask
  task automatic test_reset_mid();
    bus.i_Operand = {16'h0, 16'h0, 16'h3400};
    bus.i_Decrement = 3'b001;
    bus.i_Req = 3'b001;
    tick();
    tick();
    n_checks++; if (bus.o_Inc_Operand !== 8'h34) begin n_fail++; $display("FAIL rmid_high_inc_op got %h exp 34", bus.o_Inc_Operand); end
    rst = 1'b1;
    #1;
    n_checks++; if (bus.o_Busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b exp 0", bus.o_Busy); end
    n_checks++; if (bus.o_Inc_Operand !== 8'h00) begin n_fail++; $display("FAIL rmid_inc_op got %h exp 00", bus.o_Inc_Operand); end
    n_checks++; if (bus.o_Inc_Decrement !== 1'b0) begin n_fail++; $display("FAIL rmid_inc_dec got %b exp 0", bus.o_Inc_Decrement); end
    tick();
    n_checks++; if (bus.o_Ack !== 3'b000) begin n_fail++; $display("FAIL rmid_ack got %b exp 000", bus.o_Ack); end
    n_checks++; if (bus.o_Result !== 16'h0000) begin n_fail++; $display("FAIL rmid_result got %h exp 0000", bus.o_Result); end
    rst = 1'b0;
    wait_ack(n);
    bus.i_Req = 3'b000;
    n_checks++; if (n !== 3) begin n_fail++; $display("FAIL rmid_resrv_latency got %0d exp 3", n); end
    n_checks++; if (bus.o_Ack !== 3'b001) begin n_fail++; $display("FAIL rmid_resrv_ack got %b exp 001", bus.o_Ack); end
    n_checks++; if (bus.o_Result !== 16'h33FF) begin n_fail++; $display("FAIL rmid_resrv_result got %h exp 33FF", bus.o_Result); end
    tick();
  endtask
  task automatic test_skip();
    bus.i_Operand = {16'h0010, 16'h0, 16'h0};
    bus.i_Decrement = 3'b000;
    bus.i_Req = 3'b100;
    wait_ack(n);
    bus.i_Req = 3'b000;
    n_checks++; if (n !== LAT_NC) begin n_fail++; $display("FAIL skip_nc_latency got %0d exp %0d", n, LAT_NC); end
    n_checks++; if (bus.o_Result !== 16'h0011) begin n_fail++; $display("FAIL skip_nc_result got %h exp 0011", bus.o_Result); end
    tick();
    bus.i_Operand = {16'h00FF, 16'h0, 16'h0};
    bus.i_Req = 3'b100;
    wait_ack(n);
    bus.i_Req = 3'b000;
    n_checks++; if (n !== 3) begin n_fail++; $display("FAIL skip_c_latency got %0d exp 3", n); end
    n_checks++; if (bus.o_Result !== 16'h0100) begin n_fail++; $display("FAIL skip_c_result got %h exp 0100", bus.o_Result); end
    n_checks++; if (bus.o_Wrap !== 1'b0) begin n_fail++; $display("FAIL skip_c_wrap got %b exp 0", bus.o_Wrap); end
    tick();
  endtask
  initial begin
    test_reset();
    test_inc_pc();
    test_wrap();
    test_back_to_back();
    test_capture();
    test_reset_mid();
    test_skip();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
